// File: rtl/jelly_data_shifter_fifo.sv
// Stream FIFO whose buffer is a variable-tap shift register read at count-1,
// followed by a registered output stage with valid/ready handshakes.
module jelly_data_shifter_fifo #(
  parameter int SEL_WIDTH  = 5,
  parameter int NUM        = (1 << SEL_WIDTH),
  parameter int DATA_WIDTH = 8
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [SEL_WIDTH:0]    data_count
);

  localparam logic [SEL_WIDTH:0] FULL = (SEL_WIDTH+1)'(NUM);

  logic [DATA_WIDTH-1:0] r_mem [NUM];
  logic [SEL_WIDTH:0]    r_count;
  logic                  r_s_ready;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [SEL_WIDTH:0]    r_data_count;

  logic                  w_wr;
  logic                  w_ld;
  logic                  w_rel;
  logic [SEL_WIDTH:0]    w_cnt_m1;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0] w_tap;
  logic [SEL_WIDTH:0]    w_count_next;
  logic                  w_m_valid_next;

  assign w_wr     = cke & s_valid & r_s_ready;
  assign w_ld     = cke & (r_count != '0) & (~r_m_valid | m_ready);
  assign w_rel    = cke & r_m_valid & m_ready & (r_count == '0);
  assign w_cnt_m1 = r_count - (SEL_WIDTH+1)'(1);
  assign w_sel    = w_cnt_m1[SEL_WIDTH-1:0];
  // Tap is read before this edge's shift, so a concurrent write never disturbs the oldest word.
  assign w_tap    = r_mem[w_sel];

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_ld) begin
      w_count_next = r_count + (SEL_WIDTH+1)'(1);
    end else if (w_ld && !w_wr) begin
      w_count_next = r_count - (SEL_WIDTH+1)'(1);
    end
  end

  always_comb begin
    w_m_valid_next = r_m_valid;
    if (w_ld) begin
      w_m_valid_next = 1'b1;
    end else if (w_rel) begin
      w_m_valid_next = 1'b0;
    end
  end

  // Storage: one shift chain per bit, deliberately without reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = NUM - 1; i > 0; i--) begin
        r_mem[i] <= r_mem[i-1];
      end
      r_mem[0] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_data_count <= '0;
    end else if (cke) begin
      r_count      <= w_count_next;
      r_s_ready    <= (w_count_next != FULL);
      r_m_valid    <= w_m_valid_next;
      r_data_count <= w_count_next + (SEL_WIDTH+1)'(w_m_valid_next);
      if (w_ld) begin
        r_m_data <= w_tap;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign data_count = r_data_count;

endmodule
